// File: rtl/gpio_pin_filter_if.sv
// Pin-conditioning bus between the GPIO pads/prescaler side and the pin filter.
// The master drives raw pads and filter controls; the slave returns filtered pins.
interface gpio_pin_filter_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
);
    logic [WIDTH-1:0] pin_in;
    logic [WIDTH-1:0] filt_en;
    logic [CNT_W-1:0] filt_len;
    logic             sample_tick;
    logic [WIDTH-1:0] pin_filt;
    logic [WIDTH-1:0] filt_change;

    modport master (
        output pin_in,
        output filt_en,
        output filt_len,
        output sample_tick,
        input  pin_filt,
        input  filt_change
    );

    modport slave (
        input  pin_in,
        input  filt_en,
        input  filt_len,
        input  sample_tick,
        output pin_filt,
        output filt_change
    );
endinterface

// File: rtl/gpio_pin_filter.sv
// Per-pin two-flop synchroniser followed by a tick-sampled glitch filter.
// A change is accepted after filt_len+1 consecutive differing samples.
module gpio_pin_filter #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input logic              pclk,
    input logic              n_reset,
    gpio_pin_filter_if.slave bus
);

    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] s2_q;
    logic [WIDTH-1:0] filt_q;
    logic [WIDTH-1:0] filt_d;
    logic [WIDTH-1:0] chg_q;
    logic [WIDTH-1:0] chg_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

    always_comb begin
        filt_d = filt_q;
        chg_d  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (!bus.filt_en[i]) begin
                filt_d[i] = s2_q[i];
                cnt_d[i]  = '0;
                chg_d[i]  = s2_q[i] ^ filt_q[i];
            end else if (bus.sample_tick) begin
                if (s2_q[i] == filt_q[i]) begin
                    cnt_d[i] = '0;
                // >= keeps a shortened filt_len from stranding a counter above it
                end else if (cnt_q[i] >= bus.filt_len) begin
                    filt_d[i] = s2_q[i];
                    cnt_d[i]  = '0;
                    chg_d[i]  = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge pclk or negedge n_reset) begin
        if (!n_reset) begin
            s1_q   <= '0;
            s2_q   <= '0;
            filt_q <= '0;
            chg_q  <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q   <= bus.pin_in;
            s2_q   <= s1_q;
            filt_q <= filt_d;
            chg_q  <= chg_d;
            cnt_q  <= cnt_d;
        end
    end

    assign bus.pin_filt    = filt_q;
    assign bus.filt_change = chg_q;

endmodule

// File: tb/tb_gpio_pin_filter.sv
// Directed bench for gpio_pin_filter: expectations are queued with a target cycle
// when stimulus is applied and checked on the falling edge of that cycle.
module tb_gpio_pin_filter;

    logic pclk = 1'b0;
    logic n_reset;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;

    int          q_cyc  [$];
    logic [15:0] q_mask [$];
    logic [15:0] q_filt [$];
    logic [15:0] q_chg  [$];
    string       q_tag  [$];

    gpio_pin_filter_if #(.WIDTH(16), .CNT_W(4)) bus ();

    gpio_pin_filter #(.WIDTH(16), .CNT_W(4)) dut (
        .pclk   (pclk),
        .n_reset(n_reset),
        .bus    (bus)
    );

    always #5 pclk = ~pclk;

    always @(posedge pclk) cyc <= cyc + 1;

    // Scoreboard: compare every entry due this cycle, flag any that slipped past.
    always @(negedge pclk) begin
        for (int i = q_cyc.size() - 1; i >= 0; i--) begin
            if (q_cyc[i] <= cyc) begin
                n_total++;
                assert ((q_cyc[i] == cyc) &&
                        ((bus.pin_filt & q_mask[i]) === (q_filt[i] & q_mask[i])) &&
                        ((bus.filt_change & q_mask[i]) === (q_chg[i] & q_mask[i])))
                    n_pass++;
                else
                    $error("FAIL %s @cyc %0d: pin_filt=%h filt_change=%h, expected pin_filt=%h filt_change=%h (mask %h, due cyc %0d)",
                           q_tag[i], cyc, bus.pin_filt, bus.filt_change,
                           q_filt[i], q_chg[i], q_mask[i], q_cyc[i]);
                q_cyc.delete(i);
                q_mask.delete(i);
                q_filt.delete(i);
                q_chg.delete(i);
                q_tag.delete(i);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    task automatic expect_at(input int off, input logic [15:0] m, input logic [15:0] f,
                             input logic [15:0] c, input string tag);
        q_cyc.push_back(cyc + off);
        q_mask.push_back(m);
        q_filt.push_back(f);
        q_chg.push_back(c);
        q_tag.push_back(tag);
    endtask

    task automatic chk_now(input string tag, input logic [15:0] f, input logic [15:0] c);
        n_total++;
        assert ((bus.pin_filt === f) && (bus.filt_change === c))
            n_pass++;
        else
            $error("FAIL %s: pin_filt=%h filt_change=%h, expected pin_filt=%h filt_change=%h",
                   tag, bus.pin_filt, bus.filt_change, f, c);
    endtask

    initial begin
        n_reset         = 1'b1;
        bus.pin_in      = 16'h0000;
        bus.filt_en     = 16'h0000;
        bus.filt_len    = 4'd0;
        bus.sample_tick = 1'b1;
        #1 n_reset = 1'b0;
        #1 chk_now("reset_async", 16'h0000, 16'h0000);
        step(2);
        chk_now("reset_held", 16'h0000, 16'h0000);
        n_reset = 1'b1;
        step(2);

        // Bypass: 2 sync flops + output register
        bus.pin_in = 16'hA5A5;
        expect_at(1, 16'hFFFF, 16'h0000, 16'h0000, "byp_lat1");
        expect_at(2, 16'hFFFF, 16'h0000, 16'h0000, "byp_lat2");
        expect_at(3, 16'hFFFF, 16'hA5A5, 16'hA5A5, "byp_change");
        expect_at(4, 16'hFFFF, 16'hA5A5, 16'h0000, "byp_pulse_end");
        step(5);
        n_reset    = 1'b0;
        bus.pin_in = 16'h0000;
        #1 chk_now("byp_async_reset", 16'h0000, 16'h0000);
        bus.filt_en  = 16'hFFFF;
        bus.filt_len = 4'd3;
        step(2);
        n_reset = 1'b1;
        step(3);

        // Filter accept, filt_len=3: 2 + 3 + 1 = 6 cycles
        bus.pin_in = 16'h0001;
        expect_at(5, 16'hFFFF, 16'h0000, 16'h0000, "acc_before");
        expect_at(6, 16'hFFFF, 16'h0001, 16'h0001, "acc_change");
        expect_at(7, 16'hFFFF, 16'h0001, 16'h0000, "acc_pulse_end");
        step(8);

        // Glitch of 3 cycles on pin 5 is rejected
        bus.pin_in = 16'h0021;
        for (int k = 1; k <= 8; k++) expect_at(k, 16'hFFFF, 16'h0001, 16'h0000, "glitch_reject");
        step(3);
        bus.pin_in = 16'h0001;
        step(6);

        // 4-cycle pulse is accepted, and its trailing edge is filtered too
        bus.pin_in = 16'h0021;
        for (int k = 1; k <= 5; k++) expect_at(k, 16'hFFFF, 16'h0001, 16'h0000, "pulse_wait");
        expect_at(6, 16'hFFFF, 16'h0021, 16'h0020, "pulse_rise");
        for (int k = 7; k <= 9; k++) expect_at(k, 16'hFFFF, 16'h0021, 16'h0000, "pulse_high");
        expect_at(10, 16'hFFFF, 16'h0001, 16'h0020, "pulse_fall");
        expect_at(11, 16'hFFFF, 16'h0001, 16'h0000, "pulse_done");
        step(4);
        bus.pin_in = 16'h0001;
        step(8);

        // Tick gating: one tick in four, filt_len=2, accept on 3rd tick after s2 sees the edge
        bus.filt_len = 4'd2;
        for (int k = 0; k < 20; k++) begin
            bus.sample_tick = (k % 4 == 0);
            if (k == 0) begin
                for (int j = 1; j <= 12; j++) expect_at(j, 16'hFFFF, 16'h0001, 16'h0000, "tick_hold");
                expect_at(13, 16'hFFFF, 16'h0009, 16'h0008, "tick_change");
                for (int j = 14; j <= 16; j++) expect_at(j, 16'hFFFF, 16'h0009, 16'h0000, "tick_after");
            end
            if (k == 1) bus.pin_in = 16'h0009;
            step(1);
        end
        bus.sample_tick = 1'b1;

        // filt_len=15 needs 16 differing ticks
        bus.filt_len = 4'd15;
        step(2);
        bus.pin_in = 16'h0008;
        expect_at(17, 16'hFFFF, 16'h0009, 16'h0000, "len15_before");
        expect_at(18, 16'hFFFF, 16'h0008, 16'h0001, "len15_change");
        expect_at(19, 16'hFFFF, 16'h0008, 16'h0000, "len15_after");
        step(20);

        // Shrink filt_len from 15 to 2 while cnt=9: accept on next tick
        bus.pin_in = 16'h0009;
        expect_at(11, 16'hFFFF, 16'h0008, 16'h0000, "shrink_before");
        expect_at(12, 16'hFFFF, 16'h0009, 16'h0001, "shrink_change");
        expect_at(13, 16'hFFFF, 16'h0009, 16'h0000, "shrink_after");
        step(11);
        bus.filt_len = 4'd2;
        step(4);

        // Mid-count switch to bypass on pin 2
        bus.filt_len = 4'd7;
        bus.pin_in   = 16'h000D;
        expect_at(6, 16'hFFFF, 16'h0009, 16'h0000, "mode_counting");
        expect_at(7, 16'hFFFF, 16'h000D, 16'h0004, "mode_bypass");
        expect_at(8, 16'hFFFF, 16'h000D, 16'h0000, "mode_after");
        step(6);
        bus.filt_en = 16'hFFFB;
        step(4);

        // Reset mid-count on pin 0: no pulse on release
        bus.filt_en = 16'hFFFF;
        bus.pin_in  = 16'h000C;
        step(5);
        n_reset    = 1'b0;
        bus.pin_in = 16'h0000;
        #1 chk_now("midcount_reset", 16'h0000, 16'h0000);
        step(2);
        n_reset = 1'b1;
        for (int k = 1; k <= 6; k++) expect_at(k, 16'hFFFF, 16'h0000, 16'h0000, "release_quiet");
        step(8);

        n_total++;
        assert (q_cyc.size() == 0)
            n_pass++;
        else
            $error("FAIL scoreboard_drain: %0d entries left, expected 0", q_cyc.size());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
